// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: decodes the latched
// instruction, commits its result and serves two write-through read ports.
module wb_regfile #(
  parameter int NREG  = 32,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] curr_pc_plus_1,
  input  logic [31:0]      curr_instruction,
  input  logic [WIDTH-1:0] curr_O,
  input  logic [WIDTH-1:0] curr_D,
  input  logic [AW-1:0]    read_addr_a,
  input  logic [AW-1:0]    read_addr_b,
  output logic [WIDTH-1:0] read_data_a,
  output logic [WIDTH-1:0] read_data_b,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  logic [4:0]       opcode;
  logic [4:0]       rd;
  logic [26:0]      target;
  logic             wb_we;
  logic [WIDTH-1:0] regs [NREG];

  assign opcode = curr_instruction[31:27];
  assign rd     = curr_instruction[26:22];
  assign target = curr_instruction[26:0];

  // Non-writing and undefined opcodes fall through to the no-write default.
  always_comb begin
    wb_we   = 1'b0;
    wb_addr = AW'(rd);
    wb_data = curr_O;
    case (opcode)
      OP_RTYPE, OP_ADDI: wb_we = 1'b1;
      OP_LW: begin
        wb_we   = 1'b1;
        wb_data = curr_D;
      end
      OP_JAL: begin
        wb_we   = 1'b1;
        wb_addr = AW'(31);
        wb_data = curr_pc_plus_1;
      end
      OP_SETX: begin
        wb_we   = 1'b1;
        wb_addr = AW'(30);
        wb_data = WIDTH'(target);
      end
      default: wb_we = 1'b0;
    endcase
  end

  assign wb_valid = enable && wb_we && (wb_addr != '0);

  // Register 0 is never written because wb_valid excludes address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_valid) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign read_data_a = (read_addr_a == '0) ? '0 :
                       (wb_valid && (read_addr_a == wb_addr)) ? wb_data : regs[read_addr_a];
  assign read_data_b = (read_addr_b == '0) ? '0 :
                       (wb_valid && (read_addr_b == wb_addr)) ? wb_data : regs[read_addr_b];

endmodule
